// File: rtl/kf_pkg.sv
// Shared types, default widths and helpers for the steady-state Kalman estimator.
// Config words are laid out A (row-major), then B, C, K and the x preload.
package kf_pkg;

  localparam int unsigned DefW = 32;
  localparam int unsigned DefF = 16;

  typedef enum logic [2:0] {StIdle, StPred, StMeas, StResid, StCorr, StDone} kf_state_e;

  // Where the MAC result issued last cycle has to be written back.
  typedef enum logic [1:0] {DstNone, DstXp, DstX} kf_dst_e;

  // Region 0 is the N*N matrix A; each following region is one N-vector.
  function automatic int unsigned off_region(input int unsigned n, input int unsigned r);
    return (r == 32'd0) ? 32'd0 : n * n + (r - 32'd1) * n;
  endfunction

  function automatic int unsigned off_A(input int unsigned n);
    return off_region(n, 32'd0);
  endfunction

  function automatic int unsigned off_B(input int unsigned n);
    return off_region(n, 32'd1);
  endfunction

  function automatic int unsigned off_C(input int unsigned n);
    return off_region(n, 32'd2);
  endfunction

  function automatic int unsigned off_K(input int unsigned n);
    return off_region(n, 32'd3);
  endfunction

  function automatic int unsigned off_X(input int unsigned n);
    return off_region(n, 32'd4);
  endfunction

  // Clamp a wide signed value to the signed range of a w-bit word.
  function automatic logic signed [127:0] sat_w(input logic signed [127:0] v,
                                                input int unsigned w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 32'd1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 32'd1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/kf_mac.sv
// Time-shared signed MAC: W x W products into a 2W+4 accumulator; finalize rounds half
// up, drops F fraction bits and saturates, with the W-bit result valid one cycle later.
module kf_mac
  import kf_pkg::*;
#(
  parameter int unsigned W = DefW,
  parameter int unsigned F = DefF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic                i_fin,
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_res,
  output logic                o_res_vld
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned AW = 2 * W + 4;
  localparam logic signed [AW-1:0] RndHalf = {{(AW - 1){1'b0}}, 1'b1} << (F - 1);

  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_base;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_rnd;
  logic signed [AW-1:0] w_shr;
  logic signed [AW-1:0] r_acc;
  logic signed [W-1:0]  r_res;
  logic                 r_vld;

  // Clear folds into the first term so a dot product needs no idle setup cycle.
  always_comb begin
    w_prod = PW'(i_a) * PW'(i_b);
    w_base = i_clr ? '0 : r_acc;
    w_sum  = w_base + AW'(w_prod);
    w_rnd  = w_sum + RndHalf;
    w_shr  = w_rnd >>> F;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_res <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= i_en && i_fin;
      if (i_en) r_acc <= w_sum;
      if (i_en && i_fin) r_res <= W'(sat_w(128'(w_shr), W));
    end
  end

  assign o_res     = r_res;
  assign o_res_vld = r_vld;

endmodule

// File: rtl/kalman_ss_estimator.sv
// Fixed-gain Kalman estimator: xp = A*x + B*u, ybar = y - C*xp, x = xp + K*ybar,
// evaluated term by term on a single shared MAC once per sample strobe.
module kalman_ss_estimator
  import kf_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned W      = DefW,
  parameter int unsigned F      = DefF,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_begin,
  input  logic              i_meas_valid,
  input  logic [W-1:0]      i_u,
  input  logic [W-1:0]      i_y,
  input  logic              i_cfg_we,
  input  logic [ADDR_W-1:0] i_cfg_addr,
  input  logic [W-1:0]      i_cfg_data,
  output logic [N*W-1:0]    o_state,
  output logic [W-1:0]      o_resid,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_cfg_err
);

  localparam int unsigned RowW     = $clog2(N);
  localparam int unsigned ColW     = $clog2(N + 1);
  localparam int unsigned NumWords = N * N + 4 * N;

  kf_state_e           r_st;
  kf_dst_e             r_dst;
  logic [RowW-1:0]     r_row, r_dst_idx;
  logic [ColW-1:0]     r_col;
  logic                r_busy, r_meas, r_valid, r_overrun, r_cfg_err;
  logic signed [W-1:0] r_a [N][N];
  logic signed [W-1:0] r_b [N];
  logic signed [W-1:0] r_c [N];
  logic signed [W-1:0] r_k [N];
  logic signed [W-1:0] r_x [N];
  logic signed [W-1:0] r_xp [N];
  logic signed [W-1:0] r_u, r_y, r_ybar, r_resid;
  logic [N*W-1:0]      r_state;

  logic signed [W-1:0] w_mac_a, w_mac_b, w_res;
  logic                w_mac_clr, w_mac_en, w_mac_fin, w_res_vld, w_addr_ok;
  logic [RowW-1:0]     w_col;
  logic [31:0]         w_addr;
  logic signed [W-1:0] w_xp_eff [N];
  logic signed [W-1:0] w_x_eff [N];
  logic signed [W-1:0] w_x_fin [N];

  assign w_col     = r_col[RowW-1:0];
  assign w_addr    = 32'(i_cfg_addr);
  assign w_addr_ok = !r_busy && (w_addr < NumWords);

  always_comb begin
    w_mac_a   = '0;
    w_mac_b   = '0;
    w_mac_clr = 1'b0;
    w_mac_en  = 1'b0;
    w_mac_fin = 1'b0;
    unique case (r_st)
      StPred: begin
        w_mac_en  = 1'b1;
        w_mac_clr = (r_col == '0);
        if (r_col == ColW'(N)) begin
          w_mac_a   = r_b[r_row];
          w_mac_b   = r_u;
          w_mac_fin = 1'b1;
        end else begin
          w_mac_a = r_a[r_row][w_col];
          w_mac_b = r_x[w_col];
        end
      end
      StMeas: begin
        w_mac_en  = 1'b1;
        w_mac_clr = (r_row == '0);
        w_mac_fin = (r_row == RowW'(N - 1));
        w_mac_a   = r_c[r_row];
        w_mac_b   = r_xp[r_row];
      end
      StCorr: begin
        w_mac_en  = 1'b1;
        w_mac_clr = 1'b1;
        w_mac_fin = 1'b1;
        w_mac_a   = r_k[r_row];
        w_mac_b   = r_ybar;
      end
      default: ;
    endcase
  end

  // Apply the write-back of the result the MAC finished last cycle, so DONE sees final values.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_xp_eff[i] = r_xp[i];
      w_x_eff[i]  = r_x[i];
    end
    if (w_res_vld && r_dst == DstXp) w_xp_eff[r_dst_idx] = w_res;
    if (w_res_vld && r_dst == DstX) begin
      w_x_eff[r_dst_idx] = W'(sat_w(128'(r_xp[r_dst_idx]) + 128'(w_res), W));
    end
    for (int unsigned i = 0; i < N; i++) w_x_fin[i] = r_meas ? w_x_eff[i] : w_xp_eff[i];
  end

  kf_mac #(
    .W (W),
    .F (F)
  ) u_mac (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_mac_clr),
    .i_en      (w_mac_en),
    .i_fin     (w_mac_fin),
    .i_a       (w_mac_a),
    .i_b       (w_mac_b),
    .o_res     (w_res),
    .o_res_vld (w_res_vld)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st      <= StIdle;
      r_dst     <= DstNone;
      r_dst_idx <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_busy    <= 1'b0;
      r_meas    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_cfg_err <= 1'b0;
      r_u       <= '0;
      r_y       <= '0;
      r_ybar    <= '0;
      r_resid   <= '0;
      r_state   <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) r_a[i][j] <= '0;
        r_b[i]  <= '0;
        r_c[i]  <= '0;
        r_k[i]  <= '0;
        r_x[i]  <= '0;
        r_xp[i] <= '0;
      end
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= i_begin && r_busy;
      r_cfg_err <= i_cfg_we && !w_addr_ok;
      r_dst_idx <= r_row;
      r_dst     <= !w_mac_fin ? DstNone : (r_st == StPred) ? DstXp :
                   (r_st == StCorr) ? DstX : DstNone;
      for (int unsigned i = 0; i < N; i++) begin
        r_xp[i] <= w_xp_eff[i];
        r_x[i]  <= w_x_eff[i];
      end
      if (i_cfg_we && w_addr_ok) begin
        for (int unsigned i = 0; i < N; i++) begin
          for (int unsigned j = 0; j < N; j++) begin
            if (w_addr == off_A(N) + i * N + j) r_a[i][j] <= i_cfg_data;
          end
          if (w_addr == off_B(N) + i) r_b[i] <= i_cfg_data;
          if (w_addr == off_C(N) + i) r_c[i] <= i_cfg_data;
          if (w_addr == off_K(N) + i) r_k[i] <= i_cfg_data;
          if (w_addr == off_X(N) + i) r_x[i] <= i_cfg_data;
        end
      end
      unique case (r_st)
        StIdle: begin
          if (i_begin) begin
            r_u    <= i_u;
            r_y    <= i_y;
            r_meas <= i_meas_valid;
            r_ybar <= '0;
            r_busy <= 1'b1;
            r_row  <= '0;
            r_col  <= '0;
            r_st   <= StPred;
          end
        end
        StPred: begin
          if (r_col == ColW'(N)) begin
            r_col <= '0;
            if (r_row == RowW'(N - 1)) begin
              r_row <= '0;
              r_st  <= r_meas ? StMeas : StDone;
            end else begin
              r_row <= r_row + RowW'(1);
            end
          end else begin
            r_col <= r_col + ColW'(1);
          end
        end
        StMeas: begin
          if (r_row == RowW'(N - 1)) begin
            r_row <= '0;
            r_st  <= StResid;
          end else begin
            r_row <= r_row + RowW'(1);
          end
        end
        StResid: begin
          r_ybar <= W'(sat_w(128'(r_y) - 128'(w_res), W));
          r_st   <= StCorr;
        end
        StCorr: begin
          if (r_row == RowW'(N - 1)) begin
            r_row <= '0;
            r_st  <= StDone;
          end else begin
            r_row <= r_row + RowW'(1);
          end
        end
        StDone: begin
          for (int unsigned i = 0; i < N; i++) begin
            r_x[i]             <= w_x_fin[i];
            r_state[i*W +: W]  <= w_x_fin[i];
          end
          r_resid <= r_ybar;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_st    <= StIdle;
        end
        default: r_st <= StIdle;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_resid   = r_resid;
  assign o_valid   = r_valid;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_kalman_ss_estimator.sv
// Self-checking bench for kalman_ss_estimator: directed scenarios plus randomized updates
// compared against a plain-arithmetic reference of the estimator equations.
module tb_kalman_ss_estimator;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int F  = 16;
  localparam int AW = 8;
  localparam longint One = 65536;
  localparam int NumWords = N * N + 4 * N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            beg = 1'b0;
  logic            mv = 1'b0;
  logic [W-1:0]    u_s = '0;
  logic [W-1:0]    y_s = '0;
  logic            cfg_we = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [W-1:0]    cfg_data = '0;
  logic [N*W-1:0]  st;
  logic [W-1:0]    resid;
  logic            valid, busy, overrun, cfg_err;

  int n_checks = 0;
  int n_errs = 0;

  longint m_a [N][N];
  longint m_b [N];
  longint m_c [N];
  longint m_k [N];
  longint m_x [N];
  longint m_resid;

  kalman_ss_estimator #(
    .N      (N),
    .W      (W),
    .F      (F),
    .ADDR_W (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_begin      (beg),
    .i_meas_valid (mv),
    .i_u          (u_s),
    .i_y          (y_s),
    .i_cfg_we     (cfg_we),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_data   (cfg_data),
    .o_state      (st),
    .o_resid      (resid),
    .o_valid      (valid),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint rnd(input longint acc);
    return sat32((acc + One / 2) >>> F);
  endfunction

  function automatic void model_step(input longint u, input longint y, input bit mvv);
    longint xp [N];
    longint acc;
    longint yb;
    for (int i = 0; i < N; i++) begin
      acc = m_b[i] * u;
      for (int j = 0; j < N; j++) acc += m_a[i][j] * m_x[j];
      xp[i] = rnd(acc);
    end
    yb = 0;
    if (mvv) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc += m_c[i] * xp[i];
      yb = sat32(y - rnd(acc));
    end
    for (int i = 0; i < N; i++) m_x[i] = mvv ? sat32(xp[i] + rnd(m_k[i] * yb)) : xp[i];
    m_resid = yb;
  endfunction

  function automatic void model_write(input int addr, input longint d);
    if (addr < N * N) m_a[addr / N][addr % N] = d;
    else if (addr < N * N + N) m_b[addr - N * N] = d;
    else if (addr < N * N + 2 * N) m_c[addr - N * N - N] = d;
    else if (addr < N * N + 3 * N) m_k[addr - N * N - 2 * N] = d;
    else m_x[addr - N * N - 3 * N] = d;
  endfunction

  function automatic longint model_read(input int addr);
    if (addr < N * N) return m_a[addr / N][addr % N];
    if (addr < N * N + N) return m_b[addr - N * N];
    if (addr < N * N + 2 * N) return m_c[addr - N * N - N];
    if (addr < N * N + 3 * N) return m_k[addr - N * N - 2 * N];
    return m_x[addr - N * N - 3 * N];
  endfunction

  function automatic void clear_model();
    for (int a = 0; a < NumWords; a++) model_write(a, 0);
    m_resid = 0;
  endfunction

  function automatic void set_diag(input longint d);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m_a[i][j] = (i == j) ? d : 0;
  endfunction

  function automatic longint state_of(input int i);
    return longint'($signed(st[i*W +: W]));
  endfunction

  // Called at a falling edge; returns at the falling edge after the write is captured.
  task automatic cfg_write(input int addr, input longint d);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = W'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_model();
    for (int a = 0; a < NumWords; a++) cfg_write(a, model_read(a));
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < N; i++) check_eq($sformatf("%s_x%0d", tag, i), state_of(i), m_x[i]);
    check_eq({tag, "_resid"}, longint'($signed(resid)), m_resid);
  endtask

  task automatic run_update(input string tag, input longint u, input longint y, input bit mvv,
                            input int inj_ov, input int inj_cfg, input int co_addr,
                            input longint co_data);
    int cnt;
    int lat;
    lat = mvv ? N * (N + 1) + 2 * N + 2 : N * (N + 1) + 1;
    beg = 1'b1;
    u_s = W'(u);
    y_s = W'(y);
    mv  = mvv;
    if (co_addr >= 0) begin
      cfg_we   = 1'b1;
      cfg_addr = AW'(co_addr);
      cfg_data = W'(co_data);
      model_write(co_addr, co_data);
    end
    @(negedge clk);
    beg    = 1'b0;
    cfg_we = 1'b0;
    check_eq({tag, "_busy_start"}, longint'(busy), 1);
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      beg    = 1'b0;
      cfg_we = 1'b0;
      if (cnt == inj_ov + 1) check_eq({tag, "_overrun"}, longint'(overrun), 1);
      if (cnt == inj_cfg + 1) check_eq({tag, "_busy_cfg_err"}, longint'(cfg_err), 1);
      if (valid) break;
      if (cnt == inj_ov) beg = 1'b1;
      if (cnt == inj_cfg) begin
        cfg_we   = 1'b1;
        cfg_addr = AW'(N * N);
        cfg_data = 32'h7777_0000;
      end
    end
    check_eq({tag, "_latency"}, cnt, lat);
    model_step(u, y, mvv);
    check_eq({tag, "_busy_done"}, longint'(busy), 0);
    check_outputs(tag);
    @(negedge clk);
    check_eq({tag, "_valid_pulse"}, longint'(valid), 0);
  endtask

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    check_eq("rst_busy_held", longint'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_state", longint'(st), 0);
    check_eq("rst_resid", longint'(resid), 0);
    check_eq("rst_valid", longint'(valid), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_flags", longint'({overrun, cfg_err}), 0);

    // Identity hold with overrun and busy-write injected; second pass exposes a leaked B[0].
    clear_model();
    set_diag(One);
    m_x[0] = One; m_x[1] = 2 * One; m_x[2] = -3 * One; m_x[3] = One / 2;
    load_model();
    run_update("ident", 0, 0, 1'b1, 5, 12, -1, 0);
    check_eq("ident_lit_x2", state_of(2), 64'shFFFF_FFFF_FFFD_0000);
    check_eq("ident_lit_x3", state_of(3), 64'h0000_8000);
    run_update("ident2", One, 0, 1'b1, -10, -10, -1, 0);

    // Prediction only.
    clear_model();
    set_diag(One / 2);
    m_b[0] = One;
    m_x[0] = One;
    load_model();
    run_update("pred1", 2 * One, 0, 1'b0, -10, -10, -1, 0);
    check_eq("pred1_lit_x0", state_of(0), 64'h0002_8000);
    run_update("pred2", 2 * One, 0, 1'b0, -10, -10, -1, 0);
    check_eq("pred2_lit_x0", state_of(0), 64'h0003_4000);

    // Correction.
    clear_model();
    set_diag(One);
    m_c[0] = One;
    m_k[0] = One / 2;
    load_model();
    run_update("corr1", 0, 4 * One, 1'b1, -10, -10, -1, 0);
    check_eq("corr1_lit_resid", longint'($signed(resid)), 64'h0004_0000);
    run_update("corr2", 0, 4 * One, 1'b1, -10, -10, -1, 0);
    check_eq("corr2_lit_x0", state_of(0), 3 * One);

    // Saturation in both directions.
    clear_model();
    set_diag(2 * One);
    m_x[0] = 20000 * One;
    load_model();
    run_update("satp", 0, 0, 1'b0, -10, -10, -1, 0);
    check_eq("satp_lit_x0", state_of(0), 64'h7FFF_FFFF);
    m_x[0] = -20000 * One;
    cfg_write(N * N + 3 * N, m_x[0]);
    run_update("satn", 0, 0, 1'b0, -10, -10, -1, 0);
    check_eq("satn_lit_x0", state_of(0), -64'sh8000_0000);

    // Config address range.
    cfg_write(NumWords, One);
    check_eq("bad_addr_err", longint'(cfg_err), 1);
    cfg_write(NumWords - 1, 0);
    model_write(NumWords - 1, 0);
    check_eq("good_addr_err", longint'(cfg_err), 0);

    // Randomized updates, each with a config write coincident with the strobe.
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < NumWords; a++)
        model_write(a, longint'(int'($urandom_range(1 << 20)) - (1 << 19)));
      for (int i = 0; i < N; i++) m_x[i] = longint'(int'($urandom_range(1 << 21)) - (1 << 20));
      load_model();
      run_update($sformatf("rand%0d", t),
                 longint'(int'($urandom_range(1 << 23)) - (1 << 22)),
                 longint'(int'($urandom_range(1 << 23)) - (1 << 22)),
                 1'($urandom_range(1)), -10, -10, int'($urandom_range(NumWords - 1)),
                 longint'(int'($urandom_range(1 << 20)) - (1 << 19)));
    end

    // Reset in the middle of prediction with non-zero configuration loaded.
    beg = 1'b1;
    mv  = 1'b1;
    @(negedge clk);
    beg = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", longint'(busy), 0);
    check_eq("midrst_valid", longint'(valid), 0);
    check_eq("midrst_state", longint'(st), 0);
    check_eq("midrst_resid", longint'(resid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    run_update("postrst", One, 3 * One, 1'b1, -10, -10, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/kalman_ss_estimator.md
Name: kalman_ss_estimator

Overview:
- Parametrised steady-state (fixed-gain) Kalman estimator for the boost-converter MPC-MPPT loop.
- Estimates an N-state vector from a scalar input u and a scalar measurement y on each sample strobe.
- Computes xp = A·x + B·u, then yhat = C·xp, then ybar = y − yhat, then x = xp + K·ybar.
- Uses one time-shared signed MAC. Coefficients are loaded at run time through a register write port.

Parameters:
- N, 4, number of states (2..8)
- W, 32, data width; signed fixed point Q(W−F).F
- F, 16, fractional bits (1..W−2)
- ADDR_W, 8, config address width; must satisfy 2^ADDR_W ≥ N·N+4N

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_begin  in  1  sample strobe; single-cycle pulse
- i_meas_valid  in  1  sampled with i_begin; 1 = run correction, 0 = prediction only
- i_u  in  W  control input, signed
- i_y  in  W  measurement, signed
- i_cfg_we  in  1  config write strobe
- i_cfg_addr  in  ADDR_W  config word address
- i_cfg_data  in  W  config write data
- o_state  out  N·W  state vector; x[i] occupies bits [i·W +: W]
- o_resid  out  W  last residual ybar
- o_valid  out  1  one-cycle pulse when o_state/o_resid update
- o_busy  out  1  high while an update is in progress
- o_overrun  out  1  one-cycle pulse: i_begin arrived while busy
- o_cfg_err  out  1  one-cycle pulse: write rejected

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: every output 0; A, B, C, K and x all 0; FSM in IDLE.
- Address map (word addresses, row-major):
  - A[i][j] at i·N+j
  - B[i] at N·N+i
  - C[i] at N·N+N+i
  - K[i] at N·N+2N+i
  - x[i] at N·N+3N+i (state preload)
- Config writes:
  - Accepted only when o_busy=0; effective next cycle.
  - A write while busy, or to an address ≥ N·N+4N, is dropped and pulses o_cfg_err the following cycle.
- FSM: IDLE → PRED → MEAS → RESID → CORR → DONE → IDLE.
  - IDLE: i_begin=1 latches i_u, i_y and i_meas_valid, sets o_busy, and goes to PRED.
  - PRED: N·(N+1) cycles. For each row i: N terms A[i][j]·x[j], then B[i]·u. Row result goes into xp[i].
  - MEAS: N cycles; accumulates C[i]·xp[i]. Skipped if the latched meas_valid=0.
  - RESID: 1 cycle; ybar = sat(y − yhat). Skipped if meas_valid=0, in which case ybar is forced to 0.
  - CORR: N cycles; x[i] = sat(xp[i] + K[i]·ybar). If meas_valid=0, x[i] = xp[i] and CORR takes 0 cycles.
  - DONE: 1 cycle; drives o_state, o_resid and the o_valid pulse; clears o_busy. Next state IDLE.
- Latency, counted from the i_begin capture edge to o_valid high:
  - N·(N+1)+2N+2 cycles with correction (30 for N=4).
  - N·(N+1)+1 cycles without correction (21 for N=4).
  - A new i_begin can be accepted the cycle after DONE.
- A is read against the old x for the whole of PRED. x is not overwritten until CORR/DONE, so there is no read-after-write hazard.
- Arithmetic:
  - Products are full 2W-bit signed.
  - The accumulator is 2W+4 bits, cleared at the start of each dot product.
  - At the end of each dot product: add 2^(F−1), arithmetic-shift right by F (round half up), then saturate to [−2^(W−1), 2^(W−1)−1].
  - Additions y − yhat and xp + K·ybar are saturated to W bits.
- Error pulses:
  - i_begin while busy: ignored, o_overrun pulses for one cycle, the current update is unaffected.
  - i_begin coincident with a cfg write in IDLE: both are accepted; the write lands first and is used by the update.
- Reset mid-update: immediate return to IDLE; all registers cleared; no o_valid.

Decomposition:
- Package kf_pkg:
  - default W/F constants
  - address-offset functions (off_A, off_B, off_C, off_K, off_X) as functions of N
  - sat_w function
  - FSM state enum
- Sub-module kf_mac: signed W×W multiply with a 2W+4 accumulator.
  - Controls: clear, enable, and finalize (round, shift, saturate).
  - Output: the W-bit result one cycle after finalize.
  - Instantiated once.

Test Plan:
- Reset: assert i_rst_n=0 mid-PRED with non-zero config → o_busy, o_valid and o_state are 0 immediately; after release, a readback run gives x=0.
- Identity hold: A=I(0x00010000), B=C=K=0, preload x=[1.0,2.0,−3.0,0.5], i_meas_valid=1 → o_valid exactly 30 cycles after i_begin; o_state=[0x00010000,0x00020000,0xFFFD0000,0x00008000].
- Prediction only:
  - Config: A=0.5·I, B=[1.0,0,0,0], x0=1.0, u=2.0, i_meas_valid=0.
  - First update: o_valid at cycle 21; x0=2.5 (0x00028000); o_resid=0.
  - Repeat: x0=3.25.
- Correction:
  - Config: A=I, B=0, C=[1.0,0,0,0], K=[0.5,0,0,0], x=0, y=4.0.
  - First update: o_resid=0x00040000, x0=0x00020000.
  - Second update: o_resid=2.0, x0=3.0.
- Saturation: A=2.0·I, x0=20000.0 → x0=0x7FFFFFFF. With x0=−20000.0 → x0=0x80000000.
- Handshake errors:
  - i_begin while busy → o_overrun pulse; o_valid timing unchanged.
  - cfg write while busy → o_cfg_err; coefficient unchanged.
  - Write to address 32 (N=4) → o_cfg_err.
